// File: rtl/arbitro_pkg.sv
// Shared sizing defaults and destination-field helpers for the arbitro_param crossbar arbiter.
package arbitro_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int N_OUT_DEF  = 4;
    localparam int DATA_W_DEF = 12;
    localparam int MAX_W      = 64;

    // Destination field width; outputs are a power of two so this is exact.
    function automatic int dest_width(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

    // Top dest_w bits of a data_w-wide word, the word zero-extended to MAX_W.
    function automatic int unsigned dest_of(input logic [MAX_W-1:0] word,
                                            input int data_w,
                                            input int dest_w);
        logic [MAX_W-1:0] shifted;
        logic [MAX_W-1:0] mask;
        shifted = word >> (data_w - dest_w);
        mask    = (64'd1 << dest_w) - 64'd1;
        shifted = shifted & mask;
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/arbitro_param_rr_grant.sv
// Combinational grant picker: first eligible input at/after the start point, wrapping.
module rr_grant #(
    parameter int N_IN  = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_IN-1:0]  eligible_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             mode_i,
    output logic [N_IN-1:0]  grant_o
);

    // Fixed priority is round-robin with the start pinned to input 0.
    always_comb begin
        logic             found;
        logic             hit;
        logic [PTR_W-1:0] start;
        logic [PTR_W-1:0] sel;
        grant_o = '0;
        found   = 1'b0;
        start   = mode_i ? '0 : ptr_i;
        for (int k = 0; k < N_IN; k++) begin
            sel          = PTR_W'((int'(start) + k) % N_IN);
            hit          = ~found & eligible_i[sel];
            grant_o[sel] = grant_o[sel] | hit;
            found        = found | hit;
        end
    end

endmodule

// File: rtl/arbitro_param.sv
// N_IN x N_OUT FIFO crossbar arbiter: pops one eligible input head per cycle and
// pushes it one cycle later to the output FIFO named by the word's top bits.
module arbitro_param
    import arbitro_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MODE   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     active,
    input  logic [N_IN-1:0]          emptyFIFO,
    input  logic [N_IN*DATA_W-1:0]   demuxin,
    input  logic [N_OUT-1:0]         almost_fullFIFO,
    output logic [N_IN-1:0]          pop,
    output logic [N_OUT-1:0]         push,
    output logic [DATA_W-1:0]        data_out,
    output logic                     idle
);

    localparam int   DEST_W  = dest_width(N_OUT);
    localparam int   PTR_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic MODE_FP = (MODE == 1) ? 1'b1 : 1'b0;

    logic [DATA_W-1:0] head_s [N_IN];
    logic [DEST_W-1:0] dest_s [N_IN];
    logic [MAX_W-1:0]  word_ext_s;
    logic [N_IN-1:0]   eligible_s;
    logic [N_IN-1:0]   grant_s;
    logic [PTR_W-1:0]  grant_idx_s;
    logic              grant_any_s;

    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic [N_OUT-1:0]  push_q;
    logic [N_OUT-1:0]  push_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Per-input head word, destination and eligibility; reset masks every pop.
    always_comb begin
        word_ext_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            head_s[i]                  = demuxin[i*DATA_W +: DATA_W];
            word_ext_s                 = '0;
            word_ext_s[DATA_W-1:0]     = head_s[i];
            dest_s[i]                  = DEST_W'(dest_of(word_ext_s, DATA_W, DEST_W));
            eligible_s[i]              = active & ~reset & ~emptyFIFO[i]
                                         & ~almost_fullFIFO[dest_s[i]];
        end
    end

    rr_grant #(
        .N_IN  (N_IN),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .eligible_i (eligible_s),
        .ptr_i      (rr_ptr_q),
        .mode_i     (MODE_FP),
        .grant_o    (grant_s)
    );

    assign pop         = grant_s;
    assign grant_any_s = |grant_s;

    // One-hot grant to index; OR-encoding is exact because grant_s is one-hot.
    always_comb begin
        grant_idx_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            grant_idx_s = grant_idx_s | (grant_s[i] ? PTR_W'(i) : '0);
        end
    end

    // Next push strobe, held data word and advanced round-robin pointer.
    always_comb begin
        push_d   = '0;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_any_s) begin
            push_d[dest_s[grant_idx_s]] = 1'b1;
            data_d                      = head_s[grant_idx_s];
            if (grant_idx_s == PTR_W'(N_IN - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + PTR_W'(1);
            end
        end else begin
            push_d = '0;
        end
    end

    // Registered push path; reset also drops a grant made in the reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            push_q   <= '0;
            data_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            push_q   <= push_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign push     = push_q;
    assign data_out = data_q;
    assign idle     = (&emptyFIFO) & ~(|push_q);

endmodule

// File: tb/tb_arbitro_param.sv
// Bench for arbitro_param: three configurations checked against a behavioural model.
module tb_arbitro_param;

    logic clk;

    logic        a_reset, a_active, a_idle;
    logic [3:0]  a_empty, a_af, a_pop, a_push;
    logic [47:0] a_demux;
    logic [11:0] a_data;

    logic        b_reset, b_active, b_idle;
    logic [3:0]  b_empty, b_af, b_pop, b_push;
    logic [47:0] b_demux;
    logic [11:0] b_data;

    logic         c_reset, c_active, c_idle;
    logic [7:0]   c_empty, c_pop;
    logic [1:0]   c_af, c_push;
    logic [127:0] c_demux;
    logic [15:0]  c_data;

    int tests  = 0;
    int failed = 0;

    int n_in  [3] = '{4, 4, 8};
    int dw    [3] = '{12, 12, 16};
    int destw [3] = '{2, 2, 1};
    int mode  [3] = '{0, 1, 0};

    logic [7:0]  m_empty  [3];
    logic [15:0] m_head   [3][8];
    logic [3:0]  m_af     [3];
    logic        m_active [3];
    logic        m_reset  [3];
    int          m_ptr    [3];
    int          m_push   [3];
    int          m_data   [3];
    int          m_g      [3];

    arbitro_param u_a (
        .clk(clk), .reset(a_reset), .active(a_active), .emptyFIFO(a_empty),
        .demuxin(a_demux), .almost_fullFIFO(a_af), .pop(a_pop), .push(a_push),
        .data_out(a_data), .idle(a_idle)
    );

    arbitro_param #(.MODE(1)) u_b (
        .clk(clk), .reset(b_reset), .active(b_active), .emptyFIFO(b_empty),
        .demuxin(b_demux), .almost_fullFIFO(b_af), .pop(b_pop), .push(b_push),
        .data_out(b_data), .idle(b_idle)
    );

    arbitro_param #(.N_IN(8), .N_OUT(2), .DATA_W(16), .MODE(0)) u_c (
        .clk(clk), .reset(c_reset), .active(c_active), .emptyFIFO(c_empty),
        .demuxin(c_demux), .almost_fullFIFO(c_af), .pop(c_pop), .push(c_push),
        .data_out(c_data), .idle(c_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dest_m(int inst, int idx);
        return int'(m_head[inst][idx]) >> (dw[inst] - destw[inst]);
    endfunction

    // Model arbiter: scan from the start point for a non-empty head with room.
    function automatic int pick(int inst);
        int start;
        if (m_reset[inst] || !m_active[inst]) return -1;
        start = (mode[inst] == 1) ? 0 : m_ptr[inst];
        for (int k = 0; k < n_in[inst]; k++) begin
            int idx;
            idx = (start + k) % n_in[inst];
            if (!m_empty[inst][idx] && !m_af[inst][dest_m(inst, idx)]) return idx;
        end
        return -1;
    endfunction

    function automatic int all_empty(int inst);
        for (int k = 0; k < n_in[inst]; k++) begin
            if (!m_empty[inst][k]) return 0;
        end
        return 1;
    endfunction

    function automatic logic [31:0] obs_pop(int inst);
        case (inst)
            0:       return {28'd0, a_pop};
            1:       return {28'd0, b_pop};
            default: return {24'd0, c_pop};
        endcase
    endfunction

    function automatic logic [31:0] obs_push(int inst);
        case (inst)
            0:       return {28'd0, a_push};
            1:       return {28'd0, b_push};
            default: return {30'd0, c_push};
        endcase
    endfunction

    function automatic logic [31:0] obs_data(int inst);
        case (inst)
            0:       return {20'd0, a_data};
            1:       return {20'd0, b_data};
            default: return {16'd0, c_data};
        endcase
    endfunction

    function automatic logic [31:0] obs_idle(int inst);
        case (inst)
            0:       return {31'd0, a_idle};
            1:       return {31'd0, b_idle};
            default: return {31'd0, c_idle};
        endcase
    endfunction

    task automatic check(input string tag, input int inst, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s inst%0d t=%0t: observed %0h expected %0h", tag, inst, $time, obs, exp);
        end
    endtask

    task automatic drive();
        a_empty = m_empty[0][3:0]; a_af = m_af[0]; a_active = m_active[0]; a_reset = m_reset[0];
        b_empty = m_empty[1][3:0]; b_af = m_af[1]; b_active = m_active[1]; b_reset = m_reset[1];
        c_empty = m_empty[2];      c_af = m_af[2][1:0]; c_active = m_active[2]; c_reset = m_reset[2];
        for (int i = 0; i < 4; i++) begin
            a_demux[i*12 +: 12] = m_head[0][i][11:0];
            b_demux[i*12 +: 12] = m_head[1][i][11:0];
        end
        for (int i = 0; i < 8; i++) c_demux[i*16 +: 16] = m_head[2][i];
    endtask

    // One clock: drive, compare against the model before the edge, advance the model.
    task automatic cycle(input bit chk);
        drive();
        #2;
        for (int inst = 0; inst < 3; inst++) begin
            m_g[inst] = pick(inst);
            if (chk) begin
                check("pop", inst, obs_pop(inst), (m_g[inst] >= 0) ? (1 << m_g[inst]) : 0);
                check("push", inst, obs_push(inst), m_push[inst]);
                check("data_out", inst, obs_data(inst), m_data[inst]);
                check("idle", inst, obs_idle(inst),
                      (all_empty(inst) == 1 && m_push[inst] == 0) ? 1 : 0);
            end
        end
        @(posedge clk);
        for (int inst = 0; inst < 3; inst++) begin
            if (m_reset[inst]) begin
                m_ptr[inst] = 0; m_push[inst] = 0; m_data[inst] = 0;
            end else if (m_g[inst] >= 0) begin
                m_push[inst] = 1 << dest_m(inst, m_g[inst]);
                m_data[inst] = int'(m_head[inst][m_g[inst]]);
                m_ptr[inst]  = (m_g[inst] + 1) % n_in[inst];
            end else begin
                m_push[inst] = 0;
            end
        end
        #1;
    endtask

    task automatic set_idle(input int inst);
        m_empty[inst] = 8'hFF; m_af[inst] = 4'd0; m_active[inst] = 1'b1; m_reset[inst] = 1'b0;
    endtask

    initial begin
        for (int inst = 0; inst < 3; inst++) begin
            m_empty[inst] = 8'hFF; m_af[inst] = 4'd0; m_active[inst] = 1'b1;
            m_reset[inst] = 1'b1;  m_ptr[inst] = 0; m_push[inst] = 0; m_data[inst] = 0;
            for (int i = 0; i < 8; i++) m_head[inst][i] = 16'd0;
        end
        cycle(1'b0);
        cycle(1'b1);
        for (int inst = 0; inst < 3; inst++) set_idle(inst);

        // Round-robin 0..3 on the default, fixed priority 1-over-3, 8-way wrap.
        for (int i = 0; i < 4; i++) m_head[0][i] = 16'((i << 10) | $urandom_range(0, 1023));
        for (int i = 0; i < 4; i++) m_head[1][i] = 16'($urandom_range(0, 4095));
        for (int i = 0; i < 8; i++) m_head[2][i] = 16'($urandom);
        for (int k = 0; k < 9; k++) begin
            m_empty[0] = (k < 5) ? 8'hF0 : 8'hFF;
            m_empty[1] = (k < 5) ? 8'hF5 : 8'hFF;
            m_empty[2] = 8'h00;
            drive();
            #1;
            if (k < 5) check("rr_order", 0, obs_pop(0), 1 << (k % 4));
            if (k < 5) check("fixed_prio", 1, obs_pop(1), 32'h2);
            check("rr_wrap8", 2, obs_pop(2), 1 << (k % 8));
            cycle(1'b1);
            if (k < 5) check("push_dest", 0, obs_push(0), 1 << (k % 4));
            if (k < 5) check("push_word", 0, obs_data(0), int'(m_head[0][k % 4]));
            check("push_bit15", 2, obs_push(2), 1 << int'(m_head[2][k % 8][15]));
        end
        set_idle(1);
        set_idle(2);

        // Blocked destination stalls only its own input.
        m_empty[0] = 8'hFC;
        m_head[0][0] = 16'((2 << 10) | $urandom_range(0, 1023));
        m_head[0][1] = 16'((1 << 10) | $urandom_range(0, 1023));
        m_af[0] = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            drive();
            #1;
            check("hol_block", 0, obs_pop(0), 32'h2);
            cycle(1'b1);
        end
        m_af[0] = 4'b0000;
        drive();
        #1;
        check("af_release", 0, obs_pop(0), 32'h1);
        cycle(1'b1);

        // Active drop right after a pop: the registered push still completes.
        m_empty[0] = 8'hF0;
        for (int i = 0; i < 4; i++) m_head[0][i] = 16'((i << 10) | $urandom_range(0, 1023));
        cycle(1'b1);
        m_active[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive();
            #1;
            check("inactive_pop", 0, obs_pop(0), 32'h0);
            check("inactive_push", 0, obs_push(0), (k == 0) ? 32'h2 : 32'h0);
            cycle(1'b1);
        end
        m_active[0] = 1'b1;
        cycle(1'b1);

        // Reset coinciding with input 2 being the only eligible head.
        m_empty[0] = 8'hFB;
        m_reset[0] = 1'b1;
        cycle(1'b1);
        check("rst_push", 0, obs_push(0), 32'h0);
        check("rst_data", 0, obs_data(0), 32'h0);
        m_reset[0] = 1'b0;
        m_empty[0] = 8'hF0;
        drive();
        #1;
        check("rst_ptr0", 0, obs_pop(0), 32'h1);
        cycle(1'b1);

        // Random traffic on all three configurations.
        for (int n = 0; n < 300; n++) begin
            for (int inst = 0; inst < 3; inst++) begin
                m_empty[inst]  = 8'($urandom);
                m_af[inst]     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
                m_active[inst] = ($urandom_range(0, 9) != 0);
                m_reset[inst]  = ($urandom_range(0, 39) == 0);
                for (int i = 0; i < 8; i++) begin
                    m_head[inst][i] = 16'($urandom) & ((dw[inst] == 16) ? 16'hFFFF : 16'h0FFF);
                end
            end
            cycle(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
